// File: rtl/secand_pkg.sv
// Shared types for the SecAND arbiter: FSM state encoding, tag format and a clog2 helper.
package secand_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  // Tag index is sized for the largest supported requester count (8).
  localparam int TAG_IDX_W = 3;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/secand_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1 with wrap.
module rr_pick
  import secand_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // With no request pending, idx rests on the next-priority slot so the operand mux stays put.
  always_comb begin
    int c;
    gnt = '0;
    any = 1'b0;
    c   = (int'(ptr) + 1) % N_REQ;
    idx = IDX_W'(c);
    for (int i = 1; i <= N_REQ; i++) begin
      c = (int'(ptr) + i) % N_REQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = IDX_W'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secand_arb.sv
// Round-robin issue controller sharing one masked SecAND between N_REQ requesters.
// Optional SECAND_ARB_ZEROIZE_EN: zero the datapath operands/result whenever they are not valid.
module secand_arb
  import secand_pkg::*;
#(
  parameter int K_WIDTH   = 32,
  parameter int N_SHARES  = 3,
  parameter int N_REQ     = 2,
  parameter int LAT       = 1,
  parameter int MASKWIDTH = K_WIDTH * N_SHARES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  output logic [N_REQ-1:0]           req_rdy,
  input  logic [N_REQ*MASKWIDTH-1:0] req_x,
  input  logic [N_REQ*MASKWIDTH-1:0] req_y,
  output logic [N_REQ-1:0]           rsp_vld,
  output logic [MASKWIDTH-1:0]       rsp_z,
  input  logic                       rnd_vld,
  output logic                       rnd_take,
  input  logic                       hold_req,
  output logic                       hold_ack,
  output logic                       sa_dvld,
  output logic                       sa_ena,
  output logic [MASKWIDTH-1:0]       sa_x,
  output logic [MASKWIDTH-1:0]       sa_y,
  input  logic [MASKWIDTH-1:0]       sa_z,
  input  logic                       sa_ovld
);

  localparam int IDX_W = clog2(N_REQ);
  localparam int CNT_W = clog2(LAT + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic             issue, dec;
  tag_t             tag_q [LAT];
  tag_t             tag_in, tag_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;
  logic             err;
  logic [MASKWIDTH-1:0] sel_x, sel_y;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req_vld),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign issue    = (state_q == ST_RUN) && !hold_req && rnd_vld && pick_any;
  assign req_rdy  = issue ? pick_gnt : '0;
  assign sa_dvld  = issue;
  assign rnd_take = issue;
  assign sa_ena   = (state_q != ST_HALT);
  assign hold_ack = (state_q == ST_HALT);
  assign err      = err_q;

  assign sel_x  = req_x[int'(pick_idx)*MASKWIDTH +: MASKWIDTH];
  assign sel_y  = req_y[int'(pick_idx)*MASKWIDTH +: MASKWIDTH];
  assign tag_in = '{vld: issue, idx: TAG_IDX_W'(pick_idx)};
  assign tag_out = tag_q[LAT-1];

`ifdef SECAND_ARB_ZEROIZE_EN
  assign sa_x  = issue ? sel_x : '0;
  assign sa_y  = issue ? sel_y : '0;
  assign rsp_z = (|rsp_vld) ? sa_z : '0;
`else
  assign sa_x  = sel_x;
  assign sa_y  = sel_y;
  assign rsp_z = sa_z;
`endif

  // Results are steered by the tag riding alongside the op; discarded tags never strobe.
  always_comb begin
    rsp_vld = '0;
    for (int r = 0; r < N_REQ; r++) begin
      rsp_vld[r] = sa_ovld && tag_out.vld && (int'(tag_out.idx) == r);
    end
  end

  always_comb begin
    dec   = sa_ovld && (cnt_q != '0);
    cnt_d = cnt_q;
    if (issue && !dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (!issue && dec) cnt_d = cnt_q - CNT_W'(1);
  end

  // DRAIN looks at the post-update count so HALT is reached in the cycle the last result returns.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (hold_req)       state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_d == '0)    state_d = ST_HALT;
      ST_HALT:  if (!hold_req)      state_d = ST_RUN;
      default:                      state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) ptr_q <= pick_idx;
      if (sa_ovld != tag_out.vld) err_q <= 1'b1;
    end
  end

  // Tag shift register advances in lockstep with the SecAND pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else if (sa_ena) begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

endmodule

// File: tb/tb_secand_arb.sv
// Directed self-checking bench for secand_arb with a behavioural LAT=1 SecAND model.
module tb_secand_arb;

  localparam int K  = 32;
  localparam int NS = 3;
  localparam int NR = 2;
  localparam int MW = K * NS;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_vld, req_rdy, rsp_vld;
  logic [NR*MW-1:0]  req_x, req_y;
  logic [MW-1:0]     rsp_z, sa_x, sa_y, sa_z;
  logic              rnd_vld, rnd_take, hold_req, hold_ack;
  logic              sa_dvld, sa_ena, sa_ovld;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  secand_arb #(.K_WIDTH(K), .N_SHARES(NS), .N_REQ(NR), .LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x), .req_y(req_y),
    .rsp_vld(rsp_vld), .rsp_z(rsp_z),
    .rnd_vld(rnd_vld), .rnd_take(rnd_take),
    .hold_req(hold_req), .hold_ack(hold_ack),
    .sa_dvld(sa_dvld), .sa_ena(sa_ena), .sa_x(sa_x), .sa_y(sa_y),
    .sa_z(sa_z), .sa_ovld(sa_ovld)
  );

  function automatic logic [MW-1:0] mask(input logic [K-1:0] v, input logic [K-1:0] salt);
    logic [MW-1:0] r;
    logic [K-1:0]  acc;
    r   = '0;
    acc = v;
    for (int s = 1; s < NS; s++) begin
      r[s*K +: K] = salt ^ K'(s * 32'h1357_9BDF);
      acc ^= r[s*K +: K];
    end
    r[0 +: K] = acc;
    return r;
  endfunction

  function automatic logic [K-1:0] unmask(input logic [MW-1:0] m);
    logic [K-1:0] acc;
    acc = '0;
    for (int s = 0; s < NS; s++) acc ^= m[s*K +: K];
    return acc;
  endfunction

  // SecAND stand-in: one register stage, freezes with sa_ena low, remasks the product.
  logic [MW-1:0] mdl_z_q;
  logic          mdl_ovld_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_ovld_q <= 1'b0;
      mdl_z_q    <= '0;
    end else if (sa_ena) begin
      mdl_ovld_q <= sa_dvld;
      mdl_z_q    <= mask(unmask(sa_x) & unmask(sa_y), 32'hA5C3_0F96);
    end
  end
  assign sa_ovld = mdl_ovld_q;
  assign sa_z    = mdl_z_q;

  localparam logic [K-1:0] X0 = 32'hF0F0_F0F0, Y0 = 32'hFF00_FF00, Z0 = 32'hF000_F000;
  localparam logic [K-1:0] X1 = 32'h0F0F_0F0F, Y1 = 32'h00FF_FF00, Z1 = 32'h000F_0F00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_vld = '0; rnd_vld = 1'b0; hold_req = 1'b0;
    req_x = {mask(X1, 32'h2222_1111), mask(X0, 32'h1111_2222)};
    req_y = {mask(Y1, 32'h4444_3333), mask(Y0, 32'h3333_4444)};
    tick(); tick();
    checks++;
    if ({req_rdy, rsp_vld, rnd_take, sa_dvld, hold_ack} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0", {req_rdy, rsp_vld, rnd_take, sa_dvld, hold_ack});
    end
    rst = 1'b0;
    tick(); #2;
    checks++;
    if (rsp_vld !== 2'b00 || sa_ena !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release: rsp_vld=%b sa_ena=%b expected 00/1", rsp_vld, sa_ena);
    end
  endtask

  task automatic test_single();
    tick(); req_vld = 2'b01; rnd_vld = 1'b1; #2;
    checks++;
    if (req_rdy !== 2'b01 || rnd_take !== 1'b1 || sa_dvld !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_grant: rdy=%b take=%b dvld=%b expected 01/1/1", req_rdy, rnd_take, sa_dvld);
    end
    checks++;
    if (unmask(sa_x) !== X0 || unmask(sa_y) !== Y0) begin
      errors++;
      $display("[TB] FAIL single_operands: x=%h y=%h expected %h %h", unmask(sa_x), unmask(sa_y), X0, Y0);
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b01 || unmask(rsp_z) !== Z0) begin
      errors++;
      $display("[TB] FAIL single_rsp: vld=%b z=%h expected 01 %h", rsp_vld, unmask(rsp_z), Z0);
    end
    tick(); req_vld = 2'b10; #2;
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++;
      $display("[TB] FAIL single_grant1: got %b expected 10", req_rdy);
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b10 || unmask(rsp_z) !== Z1) begin
      errors++;
      $display("[TB] FAIL single_rsp1: vld=%b z=%h expected 10 %h", rsp_vld, unmask(rsp_z), Z1);
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      tick(); req_vld = 2'b11; #2;
      checks++;
      if (req_rdy !== exp_g[i]) begin
        errors++;
        $display("[TB] FAIL contention_grant%0d: got %b expected %b", i, req_rdy, exp_g[i]);
      end
      checks++;
      if (rsp_vld !== ((i == 0) ? 2'b00 : exp_g[(i == 0) ? 0 : i-1])) begin
        errors++;
        $display("[TB] FAIL contention_rsp%0d: got %b", i, rsp_vld);
      end
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b10 || unmask(rsp_z) !== Z1) begin
      errors++;
      $display("[TB] FAIL contention_last_rsp: vld=%b z=%h expected 10 %h", rsp_vld, unmask(rsp_z), Z1);
    end
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 3; i++) begin
      tick(); req_vld = 2'b11; rnd_vld = 1'b0; #2;
      checks++;
      if (req_rdy !== 2'b00 || rnd_take !== 1'b0 || sa_dvld !== 1'b0) begin
        errors++;
        $display("[TB] FAIL starve%0d: rdy=%b take=%b dvld=%b expected 00/0/0", i, req_rdy, rnd_take, sa_dvld);
      end
    end
    tick(); rnd_vld = 1'b1; #2;
    checks++;
    if (req_rdy !== 2'b01 || rnd_take !== 1'b1) begin
      errors++;
      $display("[TB] FAIL starve_release: rdy=%b take=%b expected 01/1", req_rdy, rnd_take);
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b01) begin
      errors++;
      $display("[TB] FAIL starve_rsp: got %b expected 01", rsp_vld);
    end
  endtask

  task automatic test_hold();
    tick(); req_vld = 2'b10; #2;
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++;
      $display("[TB] FAIL hold_pre_issue: got %b expected 10", req_rdy);
    end
    tick(); req_vld = 2'b01; hold_req = 1'b1; #2;
    checks++;
    if (req_rdy !== 2'b00 || sa_dvld !== 1'b0 || rsp_vld !== 2'b10 || hold_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_same_cycle: rdy=%b dvld=%b rsp=%b ack=%b expected 00/0/10/0", req_rdy, sa_dvld, rsp_vld, hold_ack);
    end
    tick(); #2;
    checks++;
    if (hold_ack !== 1'b0 || sa_ena !== 1'b1 || req_rdy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_drain: ack=%b ena=%b rdy=%b expected 0/1/00", hold_ack, sa_ena, req_rdy);
    end
    tick(); #2;
    checks++;
    if (hold_ack !== 1'b1 || sa_ena !== 1'b0 || req_rdy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_halt: ack=%b ena=%b rdy=%b expected 1/0/00", hold_ack, sa_ena, req_rdy);
    end
    tick(); hold_req = 1'b0; #2;
    checks++;
    if (hold_ack !== 1'b1 || req_rdy !== 2'b00) begin
      errors++;
      $display("[TB] FAIL hold_release_cycle: ack=%b rdy=%b expected 1/00", hold_ack, req_rdy);
    end
    tick(); #2;
    checks++;
    if (req_rdy !== 2'b01 || hold_ack !== 1'b0 || sa_ena !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_resume: rdy=%b ack=%b ena=%b expected 01/0/1", req_rdy, hold_ack, sa_ena);
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b01 || unmask(rsp_z) !== Z0) begin
      errors++;
      $display("[TB] FAIL hold_resume_rsp: vld=%b z=%h expected 01 %h", rsp_vld, unmask(rsp_z), Z0);
    end
  endtask

  task automatic test_idle_mux();
    tick(); req_vld = 2'b00; #2;
    checks++;
`ifdef SECAND_ARB_ZEROIZE_EN
    if (sa_x !== '0 || sa_y !== '0 || rsp_z !== '0) begin
      errors++;
      $display("[TB] FAIL idle_zeroize: x=%h y=%h z=%h expected all 0", sa_x, sa_y, rsp_z);
    end
`else
    if (unmask(sa_x) !== X1 || unmask(sa_y) !== Y1) begin
      errors++;
      $display("[TB] FAIL idle_next_slice: x=%h y=%h expected %h %h", unmask(sa_x), unmask(sa_y), X1, Y1);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    tick(); req_vld = 2'b10; #2;
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midflight_issue: got %b expected 10", req_rdy);
    end
    tick(); req_vld = 2'b00; rst = 1'b1; #2;
    checks++;
    if ({req_rdy, rsp_vld, rnd_take, sa_dvld, hold_ack} !== '0) begin
      errors++;
      $display("[TB] FAIL midflight_reset_outputs: got %b expected 0", {req_rdy, rsp_vld, rnd_take, sa_dvld, hold_ack});
    end
    tick(); rst = 1'b0; #2;
    checks++;
    if (rsp_vld !== 2'b00) begin
      errors++;
      $display("[TB] FAIL midflight_no_rsp: got %b expected 00", rsp_vld);
    end
    tick(); req_vld = 2'b11; #2;
    checks++;
    if (req_rdy !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midflight_ptr_reset: got %b expected 10", req_rdy);
    end
    tick(); req_vld = 2'b00; #2;
    checks++;
    if (rsp_vld !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midflight_rsp_after: got %b expected 10", rsp_vld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_hold();
    test_idle_mux();
    test_reset_midflight();
    tick();
    checks++;
    if (dut.err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_flag: got %b expected 0", dut.err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
